// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: pointer-addressed register bank on the i2c_slave byte interface.
// The first byte written in a transaction loads the pointer. Later written bytes
// are stored at the pointer, and each one advances it. Read requests return the
// byte at the pointer and also advance it. A local port shares the same bank,
// and an I2C write takes priority over a local write in the same cycle.
module i2c_reg_ctrl #(
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_busy,
  input  logic              i2c_newData,
  input  logic              i2c_dataReq,
  input  logic [7:0]        i2c_rx_data,
  output logic [7:0]        i2c_tx_data,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  input  logic              loc_we,
  output logic              loc_wack,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] pointer
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;

  logic              r_prev_busy;
  logic              r_prev_newData;
  logic              r_prev_dataReq;

  logic [7:0]        r_regs [REG_COUNT];
  logic [ADDR_W-1:0] r_pointer;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_tx_data;
  logic [7:0]        r_loc_rdata;
  logic              r_loc_wack;
  logic              r_wr_strobe;

  logic              w_busy_rise;
  logic              w_busy_fall;
  logic              w_nd_fall;
  logic              w_dr_rise;

  // Action decodes from the FSM. At most one of them is active in any cycle.
  logic              w_set_ptr;
  logic              w_i2c_wr;
  logic              w_tx_load;

  assign w_busy_rise = i2c_busy & ~r_prev_busy;
  assign w_busy_fall = ~i2c_busy & r_prev_busy;
  assign w_nd_fall   = ~i2c_newData & r_prev_newData;
  assign w_dr_rise   = i2c_dataReq & ~r_prev_dataReq;

  // Edge history. prev_busy resets high, so a transaction that is already in
  // flight when reset releases does not produce a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_busy    <= 1'b1;
      r_prev_newData <= 1'b0;
      r_prev_dataReq <= 1'b0;
    end else begin
      r_prev_busy    <= i2c_busy;
      r_prev_newData <= i2c_newData;
      r_prev_dataReq <= i2c_dataReq;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and action decode. A data action in the same cycle as a busy
  // fall still executes, and the state then returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_set_ptr   = 1'b0;
    w_i2c_wr    = 1'b0;
    w_tx_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_busy_rise) w_state_nxt = FIRST;
      end
      FIRST: begin
        if (w_nd_fall) begin
          w_set_ptr   = 1'b1;
          w_state_nxt = WRITE;
        end else if (w_dr_rise) begin
          w_tx_load   = 1'b1;
          w_state_nxt = READ;
        end
      end
      WRITE: begin
        if (w_nd_fall) begin
          w_i2c_wr = 1'b1;
        end else if (w_dr_rise) begin
          w_tx_load   = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (w_dr_rise) begin
          w_tx_load = 1'b1;
        end else if (w_nd_fall) begin
          w_i2c_wr    = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE && w_busy_fall) w_state_nxt = IDLE;
  end

  // Pointer update. The address is exactly log2(REG_COUNT) bits wide, so the
  // increment wraps from REG_COUNT-1 to 0 without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pointer <= '0;
    end else if (w_set_ptr) begin
      r_pointer <= i2c_rx_data[ADDR_W-1:0];
    end else if (w_i2c_wr || w_tx_load) begin
      r_pointer <= r_pointer + 1'b1;
    end
  end

  // Register bank. An I2C write wins over a local write. The losing local
  // write stays pending and retries in the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_i2c_wr) begin
      r_regs[r_pointer] <= i2c_rx_data;
    end else if (loc_we) begin
      r_regs[loc_addr] <= loc_wdata;
    end
  end

  // Write pulses, the last I2C write address, and the transmit byte. The
  // transmit byte holds its value between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_loc_wack  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_wr_strobe <= w_i2c_wr;
      r_loc_wack  <= loc_we & ~w_i2c_wr;
      if (w_i2c_wr)  r_wr_addr <= r_pointer;
      if (w_tx_load) r_tx_data <= r_regs[r_pointer];
    end
  end

  // Local read port. It has one cycle of latency and shows a same-cycle write
  // one cycle later.
  always_ff @(posedge clk) begin
    if (rst) r_loc_rdata <= '0;
    else     r_loc_rdata <= r_regs[loc_addr];
  end

  assign i2c_tx_data = r_tx_data;
  assign loc_rdata   = r_loc_rdata;
  assign loc_wack    = r_loc_wack;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign pointer     = r_pointer;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl. Inputs are driven 1 ns after each rising
// clock edge, and outputs are sampled at the same point.
module tb_i2c_reg_ctrl;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i2c_busy, i2c_newData, i2c_dataReq;
  logic [7:0]        i2c_rx_data, i2c_tx_data;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0]        loc_wdata;
  logic              loc_we, loc_wack;
  logic [7:0]        loc_rdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr, pointer;

  int checks   = 0;
  int failures = 0;

  i2c_reg_ctrl #(.REG_COUNT(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i2c_busy(i2c_busy), .i2c_newData(i2c_newData), .i2c_dataReq(i2c_dataReq),
    .i2c_rx_data(i2c_rx_data), .i2c_tx_data(i2c_tx_data),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we),
    .loc_wack(loc_wack), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .pointer(pointer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    i2c_busy = 1'b1;
    tick();
  endtask

  task automatic bus_stop();
    i2c_busy = 1'b0;
    tick();
    tick();
  endtask

  // Sends one byte. The outputs are returned as seen just after the commit edge.
  task automatic send_byte(input logic [7:0] b, output logic stb, output logic [ADDR_W-1:0] wa);
    i2c_rx_data = b;
    i2c_newData = 1'b1;
    tick();
    i2c_newData = 1'b0;
    tick();
    stb = wr_strobe;
    wa  = wr_addr;
  endtask

  // Sends one read request. Returns i2c_tx_data one clock after the rising edge.
  task automatic data_req(output logic [7:0] tx);
    i2c_dataReq = 1'b1;
    tick();
    tx = i2c_tx_data;
    i2c_dataReq = 1'b0;
    tick();
  endtask

  task automatic rd_loc(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    loc_addr = a;
    tick();
    d = loc_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; i2c_busy = 1'b0; i2c_newData = 1'b0; i2c_dataReq = 1'b0;
    i2c_rx_data = '0; loc_addr = '0; loc_wdata = '0; loc_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (i2c_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", i2c_tx_data); end
    checks++; if (loc_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", loc_rdata); end
    checks++; if (loc_wack !== 1'b0) begin failures++; $display("FAIL reset_wack got=%b exp=0", loc_wack); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
    checks++; if (wr_addr !== 4'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (pointer !== 4'd0) begin failures++; $display("FAIL reset_pointer got=%0d exp=0", pointer); end
  endtask

  task automatic test_burst_write();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] d;
    bus_start();
    send_byte(8'h03, stb, wa);
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL burst_ptr_strobe got=%b exp=0", stb); end
    send_byte(8'hAA, stb, wa);
    checks++; if (stb !== 1'b1 || wa !== 4'd3) begin failures++; $display("FAIL burst_wr1 got=%b/%0d exp=1/3", stb, wa); end
    send_byte(8'hBB, stb, wa);
    checks++; if (stb !== 1'b1 || wa !== 4'd4) begin failures++; $display("FAIL burst_wr2 got=%b/%0d exp=1/4", stb, wa); end
    tick();
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL burst_strobe_pulse got=%b exp=0", wr_strobe); end
    checks++; if (pointer !== 4'd5) begin failures++; $display("FAIL burst_pointer got=%0d exp=5", pointer); end
    bus_stop();
    rd_loc(4'd3, d);
    checks++; if (d !== 8'hAA) begin failures++; $display("FAIL burst_reg3 got=%h exp=AA", d); end
    rd_loc(4'd4, d);
    checks++; if (d !== 8'hBB) begin failures++; $display("FAIL burst_reg4 got=%h exp=BB", d); end
  endtask

  task automatic test_read_after_ptr();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] tx;
    bus_start();
    send_byte(8'h03, stb, wa);
    bus_stop();
    bus_start();
    data_req(tx);
    checks++; if (tx !== 8'hAA) begin failures++; $display("FAIL read_tx1 got=%h exp=AA", tx); end
    data_req(tx);
    checks++; if (tx !== 8'hBB) begin failures++; $display("FAIL read_tx2 got=%h exp=BB", tx); end
    checks++; if (pointer !== 4'd5) begin failures++; $display("FAIL read_pointer got=%0d exp=5", pointer); end
    bus_stop();
    checks++; if (i2c_tx_data !== 8'hBB) begin failures++; $display("FAIL read_tx_hold got=%h exp=BB", i2c_tx_data); end
  endtask

  task automatic test_wrap();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] d;
    bus_start();
    send_byte(8'h0F, stb, wa);
    send_byte(8'h11, stb, wa);
    send_byte(8'h22, stb, wa);
    checks++; if (wa !== 4'd0) begin failures++; $display("FAIL wrap_wr_addr got=%0d exp=0", wa); end
    checks++; if (pointer !== 4'd1) begin failures++; $display("FAIL wrap_pointer got=%0d exp=1", pointer); end
    bus_stop();
    rd_loc(4'd15, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL wrap_reg15 got=%h exp=11", d); end
    rd_loc(4'd0, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL wrap_reg0 got=%h exp=22", d); end
    bus_start();
    send_byte(8'hF2, stb, wa);
    checks++; if (pointer !== 4'd2) begin failures++; $display("FAIL wrap_ptr_upper got=%0d exp=2", pointer); end
    bus_stop();
  endtask

  task automatic test_local();
    logic [7:0] d;
    loc_addr = 4'd7; loc_wdata = 8'h5A; loc_we = 1'b1;
    tick();
    checks++; if (loc_wack !== 1'b1) begin failures++; $display("FAIL local_wack got=%b exp=1", loc_wack); end
    loc_we = 1'b0;
    tick();
    checks++; if (loc_wack !== 1'b0) begin failures++; $display("FAIL local_wack_pulse got=%b exp=0", loc_wack); end
    rd_loc(4'd7, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL local_reg7 got=%h exp=5A", d); end
    checks++; if (pointer !== 4'd2) begin failures++; $display("FAIL local_pointer got=%0d exp=2", pointer); end
  endtask

  task automatic test_collision();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] d;
    bus_start();
    send_byte(8'h04, stb, wa);
    i2c_rx_data = 8'h66; i2c_newData = 1'b1;
    tick();
    i2c_newData = 1'b0;
    loc_we = 1'b1; loc_addr = 4'd4; loc_wdata = 8'h55;
    tick();
    checks++; if (loc_wack !== 1'b0 || wr_strobe !== 1'b1) begin failures++; $display("FAIL coll_stall got=wack%b/stb%b exp=wack0/stb1", loc_wack, wr_strobe); end
    tick();
    checks++; if (loc_wack !== 1'b1) begin failures++; $display("FAIL coll_retry got=%b exp=1", loc_wack); end
    loc_we = 1'b0;
    bus_stop();
    rd_loc(4'd4, d);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL coll_reg4 got=%h exp=55", d); end
    checks++; if (pointer !== 4'd5) begin failures++; $display("FAIL coll_pointer got=%0d exp=5", pointer); end
  endtask

  task automatic test_repeated_start();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] tx, d;
    bus_start();
    send_byte(8'h02, stb, wa);
    send_byte(8'h77, stb, wa);
    data_req(tx);
    checks++; if (tx !== 8'hAA) begin failures++; $display("FAIL rs_tx got=%h exp=AA", tx); end
    checks++; if (pointer !== 4'd4) begin failures++; $display("FAIL rs_pointer got=%0d exp=4", pointer); end
    bus_stop();
    rd_loc(4'd2, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL rs_reg2 got=%h exp=77", d); end
  endtask

  task automatic test_reset_mid();
    logic stb; logic [ADDR_W-1:0] wa; logic [7:0] d;
    bus_start();
    send_byte(8'h08, stb, wa);
    send_byte(8'h01, stb, wa);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (i2c_tx_data !== 8'h00 || wr_addr !== 4'd0 || pointer !== 4'd0 || loc_rdata !== 8'h00)
      begin failures++; $display("FAIL mid_reset_outs got=tx%h wa%0d p%0d rd%h exp=all 0", i2c_tx_data, wr_addr, pointer, loc_rdata); end
    send_byte(8'h99, stb, wa);
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL mid_ignored1 got=%b exp=0", stb); end
    send_byte(8'h99, stb, wa);
    checks++; if (stb !== 1'b0 || pointer !== 4'd0) begin failures++; $display("FAIL mid_ignored2 got=%b/%0d exp=0/0", stb, pointer); end
    rd_loc(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_reg8 got=%h exp=00", d); end
    rd_loc(4'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_reg0 got=%h exp=00", d); end
    bus_stop();
    bus_start();
    send_byte(8'h05, stb, wa);
    send_byte(8'h3C, stb, wa);
    checks++; if (stb !== 1'b1 || wa !== 4'd5) begin failures++; $display("FAIL mid_resume got=%b/%0d exp=1/5", stb, wa); end
    bus_stop();
    rd_loc(4'd5, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL mid_reg5 got=%h exp=3C", d); end
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_read_after_ptr();
    test_wrap();
    test_local();
    test_collision();
    test_repeated_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
- Register-bank controller that sits on the byte interface of i2c_slave and sequences it as a pointer-addressed register map.
- First byte written in a transaction sets the register pointer; later written bytes store with auto-increment. Read bytes are served from the pointer with auto-increment.
- A local port lets on-board logic read and write the same bank. I2C writes have priority over local writes.

Parameters:
- REG_COUNT, 16, number of 8-bit registers; power of 2, min 2.
- ADDR_W, 4, pointer/address width; equals log2(REG_COUNT).

Ports:
- clk  input  1  system clock; same clock as i2c_slave.
- rst  input  1  synchronous, active-high reset.
- i2c_busy  input  1  from slave busy; high while the slave is addressed.
- i2c_newData  input  1  from slave newData; received byte valid, committed on its falling edge.
- i2c_dataReq  input  1  from slave dataReq; rising edge requests the next transmit byte.
- i2c_rx_data  input  8  from slave data_o.
- i2c_tx_data  output  8  to slave data_i.
- loc_addr  input  ADDR_W  local read/write address.
- loc_wdata  input  8  local write data.
- loc_we  input  1  local write request; level, held until loc_wack.
- loc_wack  output  1  1-cycle pulse: local write committed.
- loc_rdata  output  8  registered regs[loc_addr].
- wr_strobe  output  1  1-cycle pulse: I2C write committed.
- wr_addr  output  ADDR_W  address of the last I2C write.
- pointer  output  ADDR_W  current register pointer.

Behaviour:
- Reset values:
  - All regs 0; pointer 0; i2c_tx_data 0; loc_rdata 0; loc_wack 0; wr_strobe 0; wr_addr 0.
  - State IDLE.
  - Edge-history flops: prev_busy=1, prev_newData=0, prev_dataReq=0.
- Edge detection:
  - Each input is compared with its registered previous value: rise = cur & ~prev, fall = ~cur & prev.
  - Actions take effect at the clock edge that ends the cycle in which the edge is seen, so outputs change 1 clk after the input edge.
- FSM states: IDLE, FIRST, WRITE, READ.
  - IDLE: busy rise -> FIRST. newData and dataReq edges are ignored.
  - FIRST: newData fall -> pointer <= i2c_rx_data[ADDR_W-1:0]; upper bits ignored; -> WRITE. No register is written and wr_strobe stays 0.
  - FIRST: dataReq rise -> i2c_tx_data <= regs[pointer]; pointer++; -> READ.
  - WRITE: newData fall -> regs[pointer] <= i2c_rx_data; wr_addr <= pointer; wr_strobe=1 for 1 clk; pointer++.
  - WRITE: dataReq rise (repeated-start read) -> load and increment as in FIRST; -> READ.
  - READ: dataReq rise -> i2c_tx_data <= regs[pointer]; pointer++. newData fall -> treated as in WRITE; -> WRITE.
  - Any state except IDLE: busy fall -> IDLE.
- Pointer wraps modulo REG_COUNT (REG_COUNT-1 -> 0). Pointer persists across transactions, so a write-pointer transaction followed by a separate read transaction reads from the set address.
- Same-cycle events: a data edge and a busy fall in the same cycle -> the data action executes first, then the state goes to IDLE.
- i2c_tx_data holds its value between requests and is not cleared on busy fall.
- Local port:
  - loc_rdata <= regs[loc_addr] every cycle (1-clk latency). It reflects a same-cycle write one cycle later.
  - loc_we commits regs[loc_addr] <= loc_wdata with loc_wack=1, unless an I2C write commits in that same cycle.
  - If an I2C write commits in that cycle, the local write stalls (loc_wack=0) regardless of address and retries the next cycle.
  - A local write never moves the pointer.
- Reset mid-transaction:
  - Everything is cleared and the state is IDLE.
  - Because prev_busy resets to 1, a transaction already in flight produces no busy rise. The controller ignores it until busy falls and rises again.

Test Plan:
- Burst write: busy rise, bytes 0x03,0xAA,0xBB -> regs[3]=0xAA, regs[4]=0xBB; wr_strobe pulses twice with wr_addr 3 then 4; pointer=5.
- Read after pointer set: transaction writing 0x03 only, busy fall, then new transaction with 2 dataReq rises -> i2c_tx_data 0xAA then 0xBB, each 1 clk after its dataReq rise; pointer=5.
- Wrap: pointer byte 0x0F, write 0x11,0x22 -> regs[15]=0x11, regs[0]=0x22, pointer=1. Pointer byte 0xF2 -> pointer=2.
- Collision: loc_we=1, loc_addr=4, loc_wdata=0x55 in the same cycle an I2C write to reg 4 with 0x66 commits -> loc_wack=0 that cycle; next cycle loc_wack=1; final regs[4]=0x55.
- Repeated start: pointer 0x02, write 0x77, then dataReq rise without busy fall -> regs[2]=0x77, i2c_tx_data=regs[3], pointer=4.
- Reset mid-write: rst asserted between bytes while busy=1, then further newData falls -> no register changes and no wr_strobe until busy falls and rises again; all outputs read 0 after reset.
